// File: rtl/axilite_traffic_master.sv
// AXI4-Lite traffic master: on start, issues NUM_TXNS single-beat writes, reads,
// or writes followed by verifying reads, counting response and data errors.
module axilite_traffic_master #(
    parameter int          ADDR_WIDTH  = 64,
    parameter int          DATA_WIDTH  = 64,
    parameter int          NUM_TXNS    = 16,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter logic [63:0] ADDR_STRIDE = 64'h8,
    parameter logic [63:0] SEED        = 64'hA5A5_0000_0000_0000,
    parameter int          MODE        = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_count,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(ADDR_STRIDE);
    localparam logic [DATA_WIDTH-1:0] SEED_D   = DATA_WIDTH'(SEED);
    localparam logic [15:0]           LAST     = 16'(NUM_TXNS - 1);

    state_t      state;
    logic [15:0] idx;
    logic [15:0] nidx;
    logic [15:0] err_inc;
    logic        aw_ok, w_ok, b_err, r_err;

    // Address and data wrap silently at their port widths.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [15:0] i);
        return BASE_A + STRIDE_A * ADDR_WIDTH'(i);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] data_of(input logic [15:0] i);
        return SEED_D + DATA_WIDTH'(i);
    endfunction

    assign nidx        = idx + 16'd1;
    assign err_inc     = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    assign aw_ok       = !m_axi_awvalid || m_axi_awready;
    assign w_ok        = !m_axi_wvalid  || m_axi_wready;
    assign b_err       = m_axi_bresp != 2'b00;
    assign r_err       = (m_axi_rresp != 2'b00) || (MODE == 2 && m_axi_rdata != data_of(idx));
    assign m_axi_wstrb = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_count     <= '0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    err_count <= '0;
                    done      <= 1'b0;
                    busy      <= 1'b1;
                    idx       <= '0;
                    if (MODE == 1) begin
                        m_axi_araddr  <= addr_of(16'd0);
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_REQ;
                    end else begin
                        m_axi_awaddr  <= addr_of(16'd0);
                        m_axi_wdata   <= data_of(16'd0);
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= WR_REQ;
                    end
                end
                // AW and W retire independently; move on once both have.
                WR_REQ: begin
                    if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: if (m_axi_bvalid) begin
                    m_axi_bready <= 1'b0;
                    if (b_err) err_count <= err_inc;
                    if (idx != LAST) begin
                        idx           <= nidx;
                        m_axi_awaddr  <= addr_of(nidx);
                        m_axi_wdata   <= data_of(nidx);
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= WR_REQ;
                    end else if (MODE == 0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx           <= '0;
                        m_axi_araddr  <= addr_of(16'd0);
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_REQ;
                    end
                end
                RD_REQ: if (m_axi_arready) begin
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                    state         <= RD_RESP;
                end
                RD_RESP: if (m_axi_rvalid) begin
                    m_axi_rready <= 1'b0;
                    if (r_err) err_count <= err_inc;
                    if (idx != LAST) begin
                        idx           <= nidx;
                        m_axi_araddr  <= addr_of(nidx);
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_REQ;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_traffic_master.sv
// Directed bench: MODE 2 master against a memory slave with optional delays and
// injected faults, plus a MODE 0 master on a 16-bit address space.
module tb_axilite_traffic_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start, busy, done;
    logic [15:0] err_count;
    logic [63:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axilite_traffic_master #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .NUM_TXNS(4), .BASE_ADDR(64'h1000),
        .ADDR_STRIDE(64'h8), .SEED(64'h10), .MODE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err_count(err_count),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready), .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    logic        m0_start, m0_busy, m0_done;
    logic [15:0] m0_err;
    logic [15:0] m0_awaddr, m0_araddr;
    logic [31:0] m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [1:0]  m0_bresp, m0_rresp;

    axilite_traffic_master #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_TXNS(3), .BASE_ADDR(64'hFFF8),
        .ADDR_STRIDE(64'h8), .SEED(64'h10), .MODE(0)
    ) dut_m0 (
        .clk(clk), .rst_n(rst_n), .start(m0_start), .busy(m0_busy), .done(m0_done),
        .err_count(m0_err),
        .m_axi_awaddr(m0_awaddr), .m_axi_awvalid(m0_awvalid), .m_axi_awready(m0_awready),
        .m_axi_wdata(m0_wdata), .m_axi_wstrb(m0_wstrb), .m_axi_wvalid(m0_wvalid),
        .m_axi_wready(m0_wready), .m_axi_bresp(m0_bresp), .m_axi_bvalid(m0_bvalid),
        .m_axi_bready(m0_bready), .m_axi_araddr(m0_araddr), .m_axi_arvalid(m0_arvalid),
        .m_axi_arready(m0_arready), .m_axi_rdata(m0_rdata), .m_axi_rresp(m0_rresp),
        .m_axi_rvalid(m0_rvalid), .m_axi_rready(m0_rready)
    );

    int errors = 0;
    int checks = 0;

    // Slave configuration, set by the directed sequence.
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit          rnd;
    logic [63:0] bad_addr, bad_val, rerr_addr;
    int          viol;
    logic [63:0] mem [logic [63:0]];
    logic [63:0] wr_a[$], wr_d[$], rd_a[$];
    logic [15:0] m0_a[$];
    logic [31:0] m0_d[$];
    int          m0_ar;

    // Main memory slave: each negedge first retires the handshakes of the last
    // posedge, then decides ready/valid for the next one.
    initial begin
        bit          have_aw, have_w, have_ar, b_go, r_go, par;
        bit          p_awv, p_wv, p_arv, p_bready, p_rready;
        logic [63:0] a_addr, a_data, r_addr, p_awaddr, p_wdata, p_araddr;
        int          aw_cnt, w_cnt, ar_cnt, b_wait, r_wait, d, e;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        have_aw = 0; have_w = 0; have_ar = 0; b_go = 0; r_go = 0; par = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
        a_addr = 0; a_data = 0; r_addr = 0; p_awaddr = 0; p_wdata = 0; p_araddr = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                have_aw = 0; have_w = 0; have_ar = 0; b_go = 0; r_go = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
            end else begin
                if (p_awv && !awready && (!awvalid || awaddr != p_awaddr)) viol++;
                if (p_wv  && !wready  && (!wvalid  || wdata  != p_wdata))  viol++;
                if (p_arv && !arready && (!arvalid || araddr != p_araddr)) viol++;
                if (awready) begin have_aw = 1; a_addr = awaddr; end
                if (wready)  begin have_w  = 1; a_data = wdata;  end
                if (arready) begin have_ar = 1; r_addr = araddr; end
                if (bvalid && p_bready) bvalid = 0;
                if (rvalid && p_rready) rvalid = 0;
                awready = 0; wready = 0; arready = 0;
                if (have_aw && have_w) begin
                    mem[a_addr] = a_data;
                    wr_a.push_back(a_addr);
                    wr_d.push_back(a_data);
                    have_aw = 0; have_w = 0; b_go = 1;
                    b_wait = rnd ? int'($urandom_range(0, 7)) : b_dly;
                    if (rnd) begin
                        par = !par;
                        d = int'($urandom_range(0, 3));
                        e = d + int'($urandom_range(1, 4));
                        aw_dly = par ? d : e;
                        w_dly  = par ? e : d;
                    end
                end
                if (b_go) begin
                    if (b_wait == 0) begin bvalid = 1; bresp = 2'b00; b_go = 0; end
                    else b_wait--;
                end
                if (have_ar) begin
                    rd_a.push_back(r_addr);
                    have_ar = 0; r_go = 1;
                    r_wait = rnd ? int'($urandom_range(0, 7)) : r_dly;
                end
                if (r_go) begin
                    if (r_wait == 0) begin
                        rvalid = 1;
                        rdata  = mem.exists(r_addr) ? mem[r_addr] : 64'h0;
                        if (r_addr == bad_addr) rdata = bad_val;
                        rresp  = (r_addr == rerr_addr) ? 2'b10 : 2'b00;
                        r_go   = 0;
                    end else r_wait--;
                end
                if (awvalid && !have_aw) begin
                    if (aw_cnt >= aw_dly) begin awready = 1; aw_cnt = 0; end else aw_cnt++;
                end
                if (wvalid && !have_w) begin
                    if (w_cnt >= w_dly) begin wready = 1; w_cnt = 0; end else w_cnt++;
                end
                if (arvalid && !have_ar && !r_go && !rvalid) begin
                    if (ar_cnt >= ar_dly) begin
                        arready = 1; ar_cnt = 0;
                        if (rnd) ar_dly = int'($urandom_range(0, 7));
                    end else ar_cnt++;
                end
                p_awv = awvalid; p_awaddr = awaddr; p_wv = wvalid; p_wdata = wdata;
                p_arv = arvalid; p_araddr = araddr; p_bready = bready; p_rready = rready;
            end
        end
    end

    // MODE 0 slave: always ready, every write answered with SLVERR.
    initial begin
        m0_awready = 1; m0_wready = 1; m0_bresp = 2'b10; m0_bvalid = 0;
        m0_arready = 0; m0_rvalid = 0; m0_rdata = '0; m0_rresp = 2'b00;
        forever begin
            @(negedge clk);
            m0_bvalid = m0_bready;
        end
    end

    always @(posedge clk) begin
        if (m0_awvalid && m0_awready) m0_a.push_back(m0_awaddr);
        if (m0_wvalid && m0_wready)   m0_d.push_back(m0_wdata);
        if (m0_arvalid)               m0_ar++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_a.delete(); wr_d.delete(); rd_a.delete();
    endtask

    task automatic set_zero_wait();
        rnd = 0; aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    endtask

    // Pulse start, then count sampled cycles from the first request to done.
    task automatic do_run(output int len);
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        len = 1;
        chk("busy_after_start", busy, 1);
        chk("awvalid_after_start", awvalid, 1);
        while (!done && len < 600) begin
            @(negedge clk);
            len++;
        end
    endtask

    initial begin
        int len;
        start = 0; m0_start = 0; m0_ar = 0; viol = 0;
        bad_addr = '1; bad_val = '0; rerr_addr = '1;
        set_zero_wait();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_count, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid}, 0);
        chk("rst_readys", {bready, rready}, 0);
        chk("rst_wstrb", wstrb, 8'hFF);
        chk("rst_awaddr", awaddr, 0);
        rst_n = 1;
        @(negedge clk);

        // Zero-wait MODE 2 run
        clear_logs();
        do_run(len);
        chk("run_len", len, 17);
        chk("done_a", done, 1);
        chk("busy_fin", busy, 0);
        chk("err_a", err_count, 0);
        chk("wr_count", wr_a.size(), 4);
        chk("rd_count", rd_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr_addr%0d", i), wr_a[i], 64'h1000 + 64'(8 * i));
            chk($sformatf("wr_data%0d", i), wr_d[i], 64'h10 + 64'(i));
            chk($sformatf("rd_addr%0d", i), rd_a[i], 64'h1000 + 64'(8 * i));
        end
        @(negedge clk);
        chk("done_held", done, 1);

        // Corrupted read data and a read error response
        bad_addr = 64'h1008; bad_val = 64'h99; rerr_addr = 64'h1018;
        do_run(len);
        chk("err_b", err_count, 2);
        chk("done_b", done, 1);
        bad_addr = '1; rerr_addr = '1;

        // Random delays, AW/W order alternating per transaction
        mem.delete(); clear_logs(); viol = 0;
        rnd = 1; aw_dly = 0; w_dly = 3; b_dly = 2; ar_dly = 1; r_dly = 4;
        do_run(len);
        chk("done_c", done, 1);
        chk("err_c", err_count, 0);
        chk("valid_stable", viol, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("mem%0d", i), mem.exists(64'h1000 + 64'(8 * i)) ? mem[64'h1000 + 64'(8 * i)] : 64'hDEAD, 64'h10 + 64'(i));

        // Reset while in WR_REQ, then a clean rerun from idx 0
        set_zero_wait(); aw_dly = 5; w_dly = 5;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_wvalid", wvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        #2 rst_n = 1;
        set_zero_wait(); clear_logs();
        do_run(len);
        chk("rerun_len", len, 17);
        chk("rerun_first_addr", wr_a.size() > 0 ? wr_a[0] : 64'hDEAD, 64'h1000);
        chk("rerun_wr_count", wr_a.size(), 4);
        chk("rerun_err", err_count, 0);

        // MODE 0, bresp error on every write, 16-bit address wrap
        @(negedge clk) m0_start = 1;
        @(negedge clk) m0_start = 0;
        len = 0;
        while (!m0_done && len < 100) begin
            @(negedge clk);
            len++;
        end
        chk("m0_done", m0_done, 1);
        chk("m0_err", m0_err, 3);
        chk("m0_ar", m0_ar, 0);
        chk("m0_count", m0_a.size(), 3);
        chk("m0_addr0", m0_a.size() > 0 ? m0_a[0] : 16'hDEAD, 16'hFFF8);
        chk("m0_addr1", m0_a.size() > 1 ? m0_a[1] : 16'hDEAD, 16'h0000);
        chk("m0_addr2", m0_a.size() > 2 ? m0_a[2] : 16'hDEAD, 16'h0008);
        chk("m0_data2", m0_d.size() > 2 ? m0_d[2] : 32'hDEAD, 32'h12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axilite_traffic_master.md
# axilite_traffic_master

Parametrised AXI4-Lite traffic master for the chipset NoC/AXI-Lite bridge bench and bring-up path. On a start pulse it issues a programmable sequence of single-beat AXI-Lite writes, reads, or writes followed by verifying reads. Each transaction has its own address and data. The block counts response and data-compare errors. It replaces the fixed write-only test master that drives the bridge's master port, and adds the read channel, response channels, wstrb and self-checking.

## Interface
Parameters:
- ADDR_WIDTH, 64: AXI-Lite address width.
- DATA_WIDTH, 64: AXI-Lite data width; multiple of 8.
- NUM_TXNS, 16: transactions per pass; 1..65535.
- BASE_ADDR, 0: address of transaction 0.
- ADDR_STRIDE, 8: address increment per transaction.
- SEED, 64'hA5A5_0000_0000_0000: data of transaction 0, truncated to DATA_WIDTH.
- MODE, 2: 0 = write-only, 1 = read-only (no compare), 2 = write pass, then read-and-compare pass.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset; asynchronous, active-low.
- start, in, 1: single-cycle request to begin a run; ignored while busy.
- busy, out, 1: run in progress.
- done, out, 1: run finished; held until the next accepted start or reset.
- err_count, out, 16: errors in the current or last run; saturating.
- m_axi_awaddr, out, ADDR_WIDTH: write address.
- m_axi_awvalid, out, 1: write address valid.
- m_axi_awready, in, 1: write address ready.
- m_axi_wdata, out, DATA_WIDTH: write data.
- m_axi_wstrb, out, DATA_WIDTH/8: write strobes; all ones.
- m_axi_wvalid, out, 1: write data valid.
- m_axi_wready, in, 1: write data ready.
- m_axi_bresp, in, 2: write response.
- m_axi_bvalid, in, 1: write response valid.
- m_axi_bready, out, 1: write response ready.
- m_axi_araddr, out, ADDR_WIDTH: read address.
- m_axi_arvalid, out, 1: read address valid.
- m_axi_arready, in, 1: read address ready.
- m_axi_rdata, in, DATA_WIDTH: read data.
- m_axi_rresp, in, 2: read response.
- m_axi_rvalid, in, 1: read data valid.
- m_axi_rready, out, 1: read data ready.

## Operation
- Index counter idx runs 0..NUM_TXNS-1.
- addr(idx) = BASE_ADDR + idx*ADDR_STRIDE, computed mod 2^ADDR_WIDTH (wraps silently).
- data(idx) = SEED + idx, computed mod 2^DATA_WIDTH.
- Exactly one transaction is outstanding at a time.
- FSM states:
  - IDLE: on start → WR_REQ if MODE is 0 or 2; → RD_REQ if MODE is 1. Accepting start clears err_count and done, sets idx = 0 and raises busy.
  - WR_REQ: awvalid and wvalid are both asserted. Each is dropped independently after its own handshake (valid & ready). When both handshakes have completed → WR_RESP. AW and W may complete in the same cycle or in either order.
  - WR_RESP: bready = 1. On bvalid: if bresp != 0, increment err_count. Then:
    - if idx != NUM_TXNS-1: idx++ → WR_REQ;
    - else if MODE is 0: → FIN;
    - else (MODE 2): idx = 0 → RD_REQ.
  - RD_REQ: arvalid = 1. On arready → RD_RESP.
  - RD_RESP: rready = 1. On rvalid:
    - if rresp != 0, increment err_count;
    - else if MODE is 2 and rdata != data(idx), increment err_count;
    - at most one increment per beat.
    - Then: if idx != NUM_TXNS-1: idx++ → RD_REQ; else → FIN.
  - FIN: busy = 0, done = 1 → IDLE.
- err_count saturates at 16'hFFFF.
- awaddr, wdata and araddr are registered and stable while the corresponding valid is high.

## Timing
- Reset values: all valid and ready outputs 0, busy 0, done 0, err_count 0, awaddr/wdata/araddr 0, wstrb all ones, FSM in IDLE, idx 0.
- start is sampled at edge N:
  - busy is 1 and the first awvalid/wvalid (or arvalid) is 1 after edge N+1.
- Best case, zero-wait slave: a write takes 2 cycles (request, then response).
- Best case, zero-wait slave: a read takes 2 cycles.
- Best-case MODE 2 run: 4*NUM_TXNS cycles from the first request to FIN, plus 1 cycle in FIN.
- done rises one cycle after the final response handshake.
- Valid signals never drop before their handshake.
- bready and rready are high only in WR_RESP and RD_RESP. A bvalid or rvalid arriving earlier waits.
- start arriving in the same cycle as FIN is ignored; start is accepted only in IDLE.
- Reset asserted mid-run takes effect immediately:
  - all valids drop asynchronously;
  - the run is abandoned, and done is not set.

## Test plan
- MODE 2, NUM_TXNS=4, BASE_ADDR=0x1000, STRIDE=8, SEED=0x10, zero-wait memory slave:
  - required writes: 0x1000←0x10, 0x1008←0x11, 0x1010←0x12, 0x1018←0x13;
  - then four reads of the same addresses;
  - err_count=0, done=1, run length 17 cycles.
- Same configuration, but the slave corrupts the read of 0x1008 to 0x99 and returns rresp=2 on 0x1018 → err_count=2.
- Randomised ready/valid delays (0-7 cycles), with AW and W accepted in opposite orders → no valid drops before its handshake; final memory contents are correct; err_count=0.
- MODE 0 with bresp=2 on every write, NUM_TXNS=3 → no AR traffic; err_count=3; done=1.
- Address wrap: ADDR_WIDTH=16, BASE_ADDR=0xFFF8, STRIDE=8, NUM_TXNS=2 → addresses 0xFFF8, then 0x0000.
- Reset pulse while in WR_REQ → outputs return to reset values in the same cycle. A new start then runs the full sequence from idx 0.
